// File: rtl/mem_arbiter.sv
// Two-master single-port data memory arbiter: round-robin, bounded lock bursts.
// Optional macro MEM_ARB_FIXED_PRIO_EN selects fixed master-0 priority.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_lock,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_lock,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  input  logic [DATA_WIDTH-1:0] mem_in,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data
);

  localparam int          CW   = $clog2(MAX_BURST + 1);
  localparam logic [31:0] MAXB = 32'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_t;

  state_t        state;
  state_t        nxt;
  logic          last;
  logic [CW-1:0] burst_cnt;
  logic          own0;
  logic          own1;
  logic          acc;
  logic          lock_eff;
  logic          cnt_ok;
  logic          stay;

  assign own0 = (state == OWN0);
  assign own1 = (state == OWN1);

  assign m0_gnt = own0 & m0_req;
  assign m1_gnt = own1 & m1_req;
  assign acc    = m0_gnt | m1_gnt;

  assign m0_rdata = mem_in;
  assign m1_rdata = mem_in;

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    unique case (1'b1)
      own0: begin
        mem_we   = m0_we & m0_req;
        mem_addr = m0_addr;
        mem_data = m0_wdata;
      end
      own1: begin
        mem_we   = m1_we & m1_req;
        mem_addr = m1_addr;
        mem_data = m1_wdata;
      end
      default: ;
    endcase
  end

  assign cnt_ok = (32'(burst_cnt) + 32'd1) < MAXB;

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Master 1 can never hold the port against master 0.
  logic unused_m1_lock;
  assign unused_m1_lock = m1_lock;
  assign lock_eff = own0 & m0_lock;

  always_comb begin
    nxt = IDLE;
    if (m0_req)
      nxt = OWN0;
    else if (m1_req)
      nxt = OWN1;
  end
`else
  assign lock_eff = own0 ? m0_lock : m1_lock;

  // On exit the other master goes first; in IDLE a tie goes to !last.
  always_comb begin
    nxt = IDLE;
    unique case (1'b1)
      own0: nxt = m1_req ? OWN1 : (m0_req ? OWN0 : IDLE);
      own1: nxt = m0_req ? OWN0 : (m1_req ? OWN1 : IDLE);
      default: begin
        if (m0_req & m1_req)
          nxt = last ? OWN0 : OWN1;
        else if (m0_req)
          nxt = OWN0;
        else if (m1_req)
          nxt = OWN1;
      end
    endcase
  end
`endif

  assign stay = acc & lock_eff & cnt_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      burst_cnt <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      m0_rvalid <= m0_gnt & ~m0_we;
      m1_rvalid <= m1_gnt & ~m1_we;
      if (acc)
        last <= own1;
      if (stay) begin
        burst_cnt <= burst_cnt + 1'b1;
      end else begin
        burst_cnt <= '0;
        state     <= nxt;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic
// against a transaction-level arbitration model with its own memory image.
module tb_mem_arbiter;

  localparam int AW   = 6;
  localparam int DW   = 16;
  localparam int MAXB = 4;
`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req = 1'b0, m0_lock = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m0_gnt, m0_rvalid;
  logic [DW-1:0] m0_rdata;
  logic          m1_req = 1'b0, m1_lock = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m1_gnt, m1_rvalid;
  logic [DW-1:0] m1_rdata;
  logic [DW-1:0] mem_in;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_BURST (MAXB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m0_req   (m0_req),
    .m0_lock  (m0_lock),
    .m0_we    (m0_we),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_gnt   (m0_gnt),
    .m0_rvalid(m0_rvalid),
    .m0_rdata (m0_rdata),
    .m1_req   (m1_req),
    .m1_lock  (m1_lock),
    .m1_we    (m1_we),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_gnt   (m1_gnt),
    .m1_rvalid(m1_rvalid),
    .m1_rdata (m1_rdata),
    .mem_in   (mem_in),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 5)
      return 16'h1234;
    return 16'(i * 257) ^ 16'h5a5a;
  endfunction

  // Memory environment: registered read, reloaded while rst is high.
  logic [DW-1:0] mem [64];
  always @(posedge clk) begin
    mem_in <= mem[mem_addr];
    if (rst) begin
      for (int i = 0; i < 64; i++)
        mem[i] <= init_val(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_data;
    end
  end

  typedef struct packed {
    logic          vld;
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } item_t;

  item_t q0[$];
  item_t q1[$];

  int nerr = 0;
  int nchk = 0;

  // Reference model: owner (-1 none), last winner, burst length, pending read.
  int            own = -1;
  int            last = 1;
  int            cnt = 0;
  int            pend = -1;
  logic [DW-1:0] pdata = '0;
  logic [DW-1:0] mm [64];

  int            t = 0;
  int            tg  [64];
  int            trv [64];
  logic [DW-1:0] trd [64];
  int            twe [64];
  logic [AW-1:0] tma [64];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int m, input bit vld, input bit we,
                      input bit lock, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    item_t it;
    it.vld  = vld;
    it.we   = we;
    it.lock = lock;
    it.addr = a;
    it.data = d;
    if (m == 0)
      q0.push_back(it);
    else
      q1.push_back(it);
  endtask

  task automatic run_cycle(input bit r);
    item_t         h [2];
    bit            rq [2];
    bit            eg [2];
    bit            ewe;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] edata;
    bit            acc;
    int            nown;
    int            ncnt;
    int            npend;
    bit            lk;
    for (int x = 0; x < 2; x++) begin
      h[x] = '0;
      h[x].addr = AW'($urandom);
      h[x].data = DW'($urandom);
      h[x].we   = 1'($urandom);
    end
    if (q0.size() > 0) h[0] = q0[0];
    if (q1.size() > 0) h[1] = q1[0];
    rq[0] = (q0.size() > 0) && h[0].vld;
    rq[1] = (q1.size() > 0) && h[1].vld;
    rst      = r;
    m0_req   = rq[0];
    m0_lock  = h[0].lock;
    m0_we    = h[0].we;
    m0_addr  = h[0].addr;
    m0_wdata = h[0].data;
    m1_req   = rq[1];
    m1_lock  = h[1].lock;
    m1_we    = h[1].we;
    m1_addr  = h[1].addr;
    m1_wdata = h[1].data;
    #1;
    eg[0] = (own == 0) && rq[0];
    eg[1] = (own == 1) && rq[1];
    ewe = 1'b0;
    eaddr = '0;
    edata = '0;
    if (own >= 0) begin
      ewe   = h[own].we && rq[own];
      eaddr = h[own].addr;
      edata = h[own].data;
    end
    chk("gnt0", 32'(m0_gnt), 32'(eg[0]));
    chk("gnt1", 32'(m1_gnt), 32'(eg[1]));
    chk("mem_we", 32'(mem_we), 32'(ewe));
    chk("mem_addr", 32'(mem_addr), 32'(eaddr));
    chk("mem_data", 32'(mem_data), 32'(edata));
    chk("rvalid0", 32'(m0_rvalid), 32'(pend == 0));
    chk("rvalid1", 32'(m1_rvalid), 32'(pend == 1));
    if (pend == 0) chk("rdata0", 32'(m0_rdata), 32'(pdata));
    if (pend == 1) chk("rdata1", 32'(m1_rdata), 32'(pdata));
    if (t < 64) begin
      tg[t]  = m0_gnt ? 0 : (m1_gnt ? 1 : -1);
      trv[t] = m0_rvalid ? 0 : (m1_rvalid ? 1 : -1);
      trd[t] = m0_rvalid ? m0_rdata : m1_rdata;
      twe[t] = int'(mem_we);
      tma[t] = mem_addr;
    end
    t++;
    // Model step.
    acc   = (own >= 0) && rq[own];
    npend = -1;
    nown  = own;
    ncnt  = 0;
    if (acc) begin
      if (h[own].we) begin
        mm[h[own].addr] = h[own].data;
      end else begin
        npend = own;
        pdata = mm[h[own].addr];
      end
    end
    if (own < 0) begin
      if (rq[0] && rq[1])
        nown = FIXED ? 0 : 1 - last;
      else
        nown = rq[0] ? 0 : (rq[1] ? 1 : -1);
    end else begin
      lk = h[own].lock && !(FIXED && own == 1);
      if (acc && lk && cnt + 1 < MAXB) begin
        ncnt = cnt + 1;
      end else if (FIXED) begin
        nown = rq[0] ? 0 : (rq[1] ? 1 : -1);
      end else begin
        nown = rq[1-own] ? 1 - own : (rq[own] ? own : -1);
      end
    end
    if (acc) last = own;
    own  = nown;
    cnt  = ncnt;
    pend = npend;
    if (r) begin
      own  = -1;
      last = 1;
      cnt  = 0;
      pend = -1;
      for (int i = 0; i < 64; i++)
        mm[i] = init_val(i);
    end
    if (q0.size() > 0 && (!h[0].vld || eg[0])) void'(q0.pop_front());
    if (q1.size() > 0 && (!h[1].vld || eg[1])) void'(q1.pop_front());
    @(negedge clk);
  endtask

  task automatic do_reset();
    q0.delete();
    q1.delete();
    run_cycle(1'b1);
    t = 0;
  endtask

  int exp3 [10];
  int exp4 [9];
  int ng0;
  int ng1;
  int nw;

  initial begin
    for (int i = 0; i < 64; i++)
      mm[i] = init_val(i);
    @(negedge clk);

    // Reset state and single read latency.
    do_reset();
    push(0, 1, 0, 0, 6'd5, 16'h0);
    repeat (4) run_cycle(1'b0);
    chk("t1_nogrant_c0", tg[0], -1);
    chk("t1_gnt_c1", tg[1], 0);
    chk("t1_rvalid_c2", trv[2], 0);
    chk("t1_rdata", 32'(trd[2]), 32'h1234);
    chk("t1_rvalid_c3", trv[3], -1);

    // m1 write then m0 read back.
    do_reset();
    push(1, 1, 1, 0, 6'd9, 16'hBEEF);
    push(0, 0, 0, 0, 6'd0, 16'h0);
    push(0, 0, 0, 0, 6'd0, 16'h0);
    push(0, 1, 0, 0, 6'd9, 16'h0);
    repeat (6) run_cycle(1'b0);
    nw = 0;
    for (int i = 0; i < 6; i++) nw += twe[i];
    chk("t2_we_cycles", nw, 1);
    chk("t2_wr_gnt", tg[1], 1);
    chk("t2_rd_gnt", tg[3], 0);
    chk("t2_rdata", 32'(trd[4]), 32'hBEEF);

    // Both masters request together from IDLE.
    exp3 = FIXED ? '{-1, 0, 0, 0, 0, -1, 1, 1, 1, 1}
                 : '{-1, 0, 1, 0, 1, 0, 1, 0, 1, -1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(0, 1, 0, 0, AW'($urandom), 16'h0);
      push(1, 1, 0, 0, AW'($urandom), 16'h0);
    end
    repeat (10) run_cycle(1'b0);
    for (int i = 0; i < 10; i++)
      chk($sformatf("t3_gnt_c%0d", i), tg[i], exp3[i]);

    // m1 locked burst against an m0 request.
    exp4 = FIXED ? '{-1, 1, 0, -1, 1, 1, 1, 1, 1}
                 : '{-1, 1, 1, 1, 1, 0, 1, 1, -1};
    do_reset();
    for (int i = 0; i < 6; i++)
      push(1, 1, 0, 1, AW'(i + 20), 16'h0);
    push(0, 0, 0, 0, 6'd0, 16'h0);
    push(0, 1, 0, 0, 6'd7, 16'h0);
    repeat (9) run_cycle(1'b0);
    for (int i = 0; i < 9; i++)
      chk($sformatf("t4_gnt_c%0d", i), tg[i], exp4[i]);

    // Reset asserted on a read grant inside an m1 burst.
    do_reset();
    for (int i = 0; i < 4; i++)
      push(1, 1, 0, 1, 6'd33, 16'h0);
    run_cycle(1'b0);
    run_cycle(1'b0);
    run_cycle(1'b1);
    run_cycle(1'b0);
    chk("t5_gnt_at_rst", tg[2], 1);
    chk("t5_gnt_after", tg[3], -1);
    chk("t5_rvalid_after", trv[3], -1);
    chk("t5_we_after", twe[3], 0);
    chk("t5_addr_after", 32'(tma[3]), 32'h0);

`ifdef MEM_ARB_FIXED_PRIO_EN
    // Continuous requests from both: m0 owns the port.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      push(0, 1, 0, 0, AW'($urandom), 16'h0);
      push(1, 1, 0, 1, AW'($urandom), 16'h0);
    end
    repeat (9) run_cycle(1'b0);
    ng0 = 0;
    ng1 = 0;
    for (int i = 1; i < 9; i++) begin
      if (tg[i] == 0) ng0++;
      if (tg[i] == 1) ng1++;
    end
    chk("t6_m0_grants", ng0, 8);
    chk("t6_m1_grants", ng1, 0);
`endif

    // Random traffic with occasional reset.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (q0.size() < 2)
        push(0, $urandom_range(0, 3) != 0, 1'($urandom),
             $urandom_range(0, 2) == 0, AW'($urandom), DW'($urandom));
      if (q1.size() < 2)
        push(1, $urandom_range(0, 3) != 0, 1'($urandom),
             $urandom_range(0, 2) == 0, AW'($urandom), DW'($urandom));
      run_cycle($urandom_range(0, 79) == 0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
